alarm_scheduler: RTL and testbench

Controller for the alarm datapath. It holds the alarm set-point and lets the user set it from push-buttons. It arms, fires, snoozes and times out the alarm against the running time-of-day, and drives the alarm indicator. It sits between the board keys/switches, the time-of-day counter (hour/minute in binary) and the LED and HEX display logic.

---
 rtl/alarm_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_alarm_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alarm_scheduler.sv
// Alarm controller: holds the alarm set-point, debounces the board keys and
// sequences arm / ring / snooze / timeout against the running time-of-day.
module alarm_scheduler #(
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int DEB_CYC    = 500000
) (
    input  logic       clk,
    input  logic       RST_N,
    input  logic [7:0] shi,
    input  logic [7:0] fen,
    input  logic       sec_tick,
    input  logic       ALM_EN,
    input  logic       SET_MODE,
    input  logic       KEY_HOUR,
    input  logic       KEY_MIN,
    input  logic       KEY_STOP,
    input  logic       KEY_SNOOZE,
    output logic [7:0] alm_shi,
    output logic [7:0] alm_fen,
    output logic       ring,
    output logic [1:0] state
);

    localparam int SNZ_TICKS = SNOOZE_MIN * 60;
    localparam int RW = $clog2(RING_SECS + 1);
    localparam int SW = $clog2(SNZ_TICKS + 1);
    localparam int DW = $clog2(DEB_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_RINGING = 2'd2,
        S_SNOOZE  = 2'd3
    } state_t;

    logic [3:0] key_raw;
    logic [3:0] press_evt;

    assign key_raw = {KEY_SNOOZE, KEY_STOP, KEY_MIN, KEY_HOUR};

    // Bit order of press_evt: 0=HOUR 1=MIN 2=STOP 3=SNOOZE
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            logic          s1_q, s2_q;
            logic          acc_q, acc_d;
            logic          evt_q, evt_d;
            logic [DW-1:0] cnt_q, cnt_d;

            always_comb begin
                acc_d = acc_q;
                cnt_d = '0;
                if (s2_q != acc_q) begin
                    if (cnt_q == DW'(DEB_CYC - 1)) acc_d = s2_q;
                    else                            cnt_d = cnt_q + DW'(1);
                end
                evt_d = acc_q & ~acc_d;
            end

            always_ff @(posedge clk) begin
                if (!RST_N) begin
                    s1_q  <= 1'b1;
                    s2_q  <= 1'b1;
                    acc_q <= 1'b1;
                    cnt_q <= '0;
                    evt_q <= 1'b0;
                end else begin
                    s1_q  <= key_raw[gi];
                    s2_q  <= s1_q;
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                    evt_q <= evt_d;
                end
            end

            assign press_evt[gi] = evt_q;
        end
    endgenerate

    logic [7:0]    alm_shi_q, alm_shi_d, alm_fen_q, alm_fen_d;
    logic          match_q, match_d, trigger;
    state_t        state_q, state_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SW-1:0] snz_cnt_q, snz_cnt_d;
    logic          ring_q, ring_d;

    always_comb begin
        alm_shi_d = alm_shi_q;
        alm_fen_d = alm_fen_q;
        if (SET_MODE && press_evt[0]) alm_shi_d = (alm_shi_q >= 8'd23) ? 8'd0 : alm_shi_q + 8'd1;
        if (SET_MODE && press_evt[1]) alm_fen_d = (alm_fen_q >= 8'd59) ? 8'd0 : alm_fen_q + 8'd1;
    end

    // match_q tracks every cycle so a match created while editing is already "old"
    assign match_d = (shi == alm_shi_q) && (fen == alm_fen_q);
    assign trigger = match_d && !match_q;

    always_ff @(posedge clk) begin
        if (!RST_N) begin
            alm_shi_q  <= '0;
            alm_fen_q  <= '0;
            match_q    <= 1'b0;
            state_q    <= S_IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            ring_q     <= 1'b0;
        end else begin
            alm_shi_q  <= alm_shi_d;
            alm_fen_q  <= alm_fen_d;
            match_q    <= match_d;
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            ring_q     <= ring_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = '0;
        snz_cnt_d  = '0;
        if (!ALM_EN) begin
            state_d = S_IDLE;
        end else if (state_q == S_IDLE) begin
            state_d = S_ARMED;
        end else if (SET_MODE && (state_q == S_RINGING || state_q == S_SNOOZE)) begin
            state_d = S_ARMED;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (trigger && !SET_MODE) state_d = S_RINGING;
                end
                S_RINGING: begin
                    if (press_evt[2]) begin
                        state_d = S_ARMED;
                    end else if (press_evt[3]) begin
                        state_d = S_SNOOZE;
                    end else begin
                        ring_cnt_d = ring_cnt_q;
                        if (sec_tick) begin
                            if (ring_cnt_q + RW'(1) == RW'(RING_SECS)) begin
                                state_d    = S_ARMED;
                                ring_cnt_d = '0;
                            end else begin
                                ring_cnt_d = ring_cnt_q + RW'(1);
                            end
                        end
                    end
                end
                S_SNOOZE: begin
                    if (press_evt[2]) begin
                        state_d = S_ARMED;
                    end else begin
                        snz_cnt_d = snz_cnt_q;
                        if (sec_tick) begin
                            if (snz_cnt_q + SW'(1) == SW'(SNZ_TICKS)) begin
                                state_d   = S_RINGING;
                                snz_cnt_d = '0;
                            end else begin
                                snz_cnt_d = snz_cnt_q + SW'(1);
                            end
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        ring_d = (state_d == S_RINGING);
    end

    assign alm_shi = alm_shi_q;
    assign alm_fen = alm_fen_q;
    assign ring    = ring_q;
    assign state   = state_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler with short timing parameters.
module tb_alarm_scheduler;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       RST_N;
    logic [7:0] shi, fen;
    logic       sec_tick, ALM_EN, SET_MODE;
    logic [3:0] keys_n;
    logic [7:0] alm_shi, alm_fen;
    logic       ring;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alarm_scheduler #(.RING_SECS(3), .SNOOZE_MIN(1), .DEB_CYC(DEB)) dut (
        .clk(clk), .RST_N(RST_N), .shi(shi), .fen(fen), .sec_tick(sec_tick),
        .ALM_EN(ALM_EN), .SET_MODE(SET_MODE),
        .KEY_HOUR(keys_n[0]), .KEY_MIN(keys_n[1]), .KEY_STOP(keys_n[2]), .KEY_SNOOZE(keys_n[3]),
        .alm_shi(alm_shi), .alm_fen(alm_fen), .ring(ring), .state(state)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // mask bit 0=HOUR 1=MIN 2=STOP 3=SNOOZE; held long enough to be accepted
    task automatic press(input logic [3:0] mask);
        keys_n = ~mask;
        wait_cyc(DEB + 6);
        keys_n = 4'hF;
        wait_cyc(DEB + 6);
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        wait_cyc(1);
        sec_tick = 1'b0;
        wait_cyc(1);
    endtask

    // Alarm set-point is 07:30; step the minute off and back on to make a fresh match
    task automatic retrig();
        shi = 8'd7;
        fen = 8'd29;
        wait_cyc(2);
        fen = 8'd30;
        wait_cyc(1);
    endtask

    initial begin
        RST_N = 1'b0; ALM_EN = 1'b0; SET_MODE = 1'b0; keys_n = 4'hF;
        sec_tick = 1'b0; shi = 8'd12; fen = 8'd0;
        wait_cyc(3);
        check_val("rst_alm_shi", alm_shi, 0);
        check_val("rst_alm_fen", alm_fen, 0);
        check_val("rst_ring", ring, 0);
        check_val("rst_state", state, 0);

        // 1: set-point editing and hour wrap
        RST_N = 1'b1; ALM_EN = 1'b1; SET_MODE = 1'b1;
        wait_cyc(2);
        check_val("armed_after_en", state, 1);
        repeat (7) press(4'b0001);
        repeat (30) press(4'b0010);
        SET_MODE = 1'b0;
        wait_cyc(2);
        check_val("set_shi_7", alm_shi, 7);
        check_val("set_fen_30", alm_fen, 30);
        check_val("set_state", state, 1);
        press(4'b0010);
        check_val("min_ignored_no_setmode", alm_fen, 30);
        SET_MODE = 1'b1;
        repeat (16) press(4'b0001);
        check_val("hour_23", alm_shi, 23);
        press(4'b0001);
        check_val("hour_wrap_0", alm_shi, 0);
        repeat (7) press(4'b0001);
        check_val("hour_back_7", alm_shi, 7);
        SET_MODE = 1'b0;
        wait_cyc(2);

        // 2: trigger, timeout after RING_SECS, no re-trigger
        shi = 8'd7; fen = 8'd29;
        wait_cyc(2);
        check_val("no_ring_2929", ring, 0);
        fen = 8'd30;
        wait_cyc(1);
        check_val("trig_ring", ring, 1);
        check_val("trig_state", state, 2);
        tick(); tick();
        check_val("ring_after_2_ticks", state, 2);
        tick();
        check_val("timeout_ring", ring, 0);
        check_val("timeout_state", state, 1);
        wait_cyc(10);
        check_val("no_retrig_state", state, 1);
        check_val("no_retrig_ring", ring, 0);

        // 3: snooze then re-ring then stop
        retrig();
        check_val("s3_ring", ring, 1);
        press(4'b1000);
        check_val("snooze_state", state, 3);
        check_val("snooze_ring", ring, 0);
        repeat (59) tick();
        check_val("snooze_59", state, 3);
        tick();
        check_val("snooze_end_ring", ring, 1);
        check_val("snooze_end_state", state, 2);
        press(4'b0100);
        check_val("stop_state", state, 1);
        check_val("stop_ring", ring, 0);

        // 4: STOP beats SNOOZE; held key = one event; glitch = none
        retrig();
        check_val("s4_ring", ring, 1);
        press(4'b1100);
        check_val("stop_wins_state", state, 1);
        check_val("stop_wins_ring", ring, 0);
        SET_MODE = 1'b1;
        keys_n = 4'b1110;
        wait_cyc(20);
        keys_n = 4'hF;
        wait_cyc(10);
        check_val("held_one_event", alm_shi, 8);
        keys_n = 4'b1110;
        wait_cyc(3);
        keys_n = 4'hF;
        wait_cyc(10);
        check_val("glitch_no_event", alm_shi, 8);
        repeat (23) press(4'b0001);
        check_val("s4_hour_7", alm_shi, 7);
        SET_MODE = 1'b0;
        wait_cyc(3);
        check_val("s4_no_ring_after_edit", ring, 0);

        // 5: disable while ringing, re-enable while still matching
        retrig();
        check_val("s5_ring", ring, 1);
        ALM_EN = 1'b0;
        wait_cyc(1);
        check_val("dis_state", state, 0);
        check_val("dis_ring", ring, 0);
        ALM_EN = 1'b1;
        wait_cyc(3);
        check_val("reen_state", state, 1);
        check_val("reen_ring", ring, 0);

        // 6: reset during snooze; edit set-point onto current time
        retrig();
        press(4'b1000);
        check_val("s6_snooze", state, 3);
        RST_N = 1'b0; shi = 8'd2; fen = 8'd3;
        wait_cyc(1);
        check_val("midrst_alm_shi", alm_shi, 0);
        check_val("midrst_alm_fen", alm_fen, 0);
        check_val("midrst_ring", ring, 0);
        check_val("midrst_state", state, 0);
        RST_N = 1'b1; SET_MODE = 1'b1;
        wait_cyc(2);
        repeat (2) press(4'b0001);
        repeat (3) press(4'b0010);
        SET_MODE = 1'b0;
        wait_cyc(5);
        check_val("edit_alm_shi", alm_shi, 2);
        check_val("edit_alm_fen", alm_fen, 3);
        check_val("edit_state", state, 1);
        check_val("edit_no_ring", ring, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
